modular_addsub_seq: RTL and testbench

//   Multi-cycle modular adder/subtractor: s = (x + y) mod M or (x - y) mod M, W-bit operands.

---
 rtl/modular_addsub_seq.sv | 102 ++++++++++
 tb/tb_modular_addsub_seq.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/modular_addsub_seq.sv
// Multi-cycle modular adder/subtractor, s = (x +/- y) mod M, with valid/ready on both sides.
// Optional complement output rail not_s is enabled by defining DUAL_RAIL_OUT_EN.
module modular_addsub_seq #(
  parameter int unsigned W = 8,
  parameter int unsigned M = 251
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         mode,
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] s,
  output logic         err
`ifdef DUAL_RAIL_OUT_EN
  ,
  output logic [W-1:0] not_s
`endif
);

  localparam logic [W:0]   M_EXT = (W+1)'(M);
  localparam logic [W-1:0] M_W   = W'(M);

  typedef enum logic [1:0] {IDLE, SUM, CORR, DONE} state_e;

  state_e       state_q, state_d;
  logic [W-1:0] x_q, y_q, s_q, s_d;
  logic         mode_q, err_q, err_d;
  logic [W:0]   raw_q, raw_d;
  logic         accept, xfer;

  assign accept = in_valid && (state_q == IDLE);
  assign xfer   = out_ready && (state_q == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = SUM;
      SUM:     state_d = CORR;
      CORR:    state_d = DONE;
      DONE:    if (xfer) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    s         = s_q;
    err       = err_q;
`ifdef DUAL_RAIL_OUT_EN
    not_s     = (state_q == DONE) ? ~s_q : '0;
`endif
  end

  // Corrections are done in W bits: the low W bits of raw +/- M are all that survive.
  always_comb begin
    raw_d = mode_q ? ({1'b0, x_q} - {1'b0, y_q}) : ({1'b0, x_q} + {1'b0, y_q});
    err_d = ({1'b0, x_q} >= M_EXT) || ({1'b0, y_q} >= M_EXT);
    if (mode_q) s_d = raw_q[W] ? (raw_q[W-1:0] + M_W) : raw_q[W-1:0];
    else        s_d = (raw_q >= M_EXT) ? (raw_q[W-1:0] - M_W) : raw_q[W-1:0];
    if (err_d) s_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q    <= '0;
      y_q    <= '0;
      mode_q <= 1'b0;
      raw_q  <= '0;
      s_q    <= '0;
      err_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          x_q    <= x;
          y_q    <= y;
          mode_q <= mode;
        end
        SUM:  raw_q <= raw_d;
        CORR: begin
          s_q   <= s_d;
          err_q <= err_d;
        end
        DONE: if (xfer) begin
          s_q   <= '0;
          err_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_modular_addsub_seq.sv
// Scoreboard bench for modular_addsub_seq (W=8, M=251); define DUAL_RAIL_OUT_EN to cover not_s.
module tb_modular_addsub_seq;
  localparam int W = 8;
  localparam int M = 251;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         mode = 1'b0;
  logic [W-1:0] x = '0;
  logic [W-1:0] y = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] s;
  logic         err;
`ifdef DUAL_RAIL_OUT_EN
  logic [W-1:0] not_s;
`endif

  typedef struct {
    logic [W-1:0] s;
    logic         err;
  } exp_t;

  exp_t sb[$];
  int   n_total = 0;
  int   n_bad   = 0;

  modular_addsub_seq #(.W(W), .M(M)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .mode(mode), .x(x), .y(y),
    .out_valid(out_valid), .out_ready(out_ready), .s(s), .err(err)
`ifdef DUAL_RAIL_OUT_EN
    , .not_s(not_s)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input int xa, input int ya, input logic md);
    exp_t e;
    if (xa >= M || ya >= M) begin
      e.err = 1'b1;
      e.s   = '0;
    end else begin
      e.err = 1'b0;
      e.s   = md ? W'((xa - ya + M) % M) : W'((xa + ya) % M);
    end
    return e;
  endfunction

  // Runs one transaction; hold > 0 keeps out_ready low that many cycles in DONE.
  task automatic do_op(input string tag, input int xa, input int ya, input logic md,
                       input int unsigned hold);
    int unsigned n;
    int unsigned lat;
    exp_t        e;
    logic [W-1:0] held;
    n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check({tag, ".in_ready"}, in_ready, 1);
    out_ready = (hold == 0);
    x = W'(xa); y = W'(ya); mode = md; in_valid = 1'b1;
    sb.push_back(model(xa, ya, md));
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    check({tag, ".busy"}, in_ready, 0);
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    check({tag, ".latency"}, lat, 3);
    if (sb.size() == 0) begin
      check({tag, ".sb_empty"}, 1, 0);
      return;
    end
    e = sb.pop_front();
    check({tag, ".s"}, s, e.s);
    check({tag, ".err"}, err, e.err);
`ifdef DUAL_RAIL_OUT_EN
    check({tag, ".not_s"}, not_s, ~e.s);
`endif
    held = s;
    for (int unsigned i = 0; i < hold; i++) begin
      x = 8'd9; y = 8'd9; mode = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      check({tag, ".hold_s"}, s, held);
      check({tag, ".hold_valid"}, out_valid, 1);
      check({tag, ".hold_in_ready"}, in_ready, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check({tag, ".post_valid"}, out_valid, 0);
    check({tag, ".post_s"}, s, 0);
    check({tag, ".post_err"}, err, 0);
    check({tag, ".post_in_ready"}, in_ready, 1);
`ifdef DUAL_RAIL_OUT_EN
    check({tag, ".post_not_s"}, not_s, 0);
`endif
    if (hold > 0) begin
      repeat (3) begin
        @(posedge clk); #1;
        check({tag, ".no_ghost"}, out_valid, 0);
      end
    end
  endtask

  initial begin
    int unsigned seen;
    repeat (2) @(posedge clk);
    #1;
    check("rst.out_valid", out_valid, 0);
    check("rst.s", s, 0);
    check("rst.err", err, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst.in_ready", in_ready, 1);

    do_op("add_200_100", 200, 100, 1'b0, 0);
    do_op("add_250_250", 250, 250, 1'b0, 0);
    do_op("add_eq_M", 1, 250, 1'b0, 0);
    do_op("sub_3_10", 3, 10, 1'b1, 0);
    do_op("sub_7_7", 7, 7, 1'b1, 0);
    do_op("sub_0_250", 0, 250, 1'b1, 0);
    do_op("err_x", 251, 1, 1'b0, 0);
    do_op("err_y", 5, 255, 1'b1, 0);
    do_op("bp", 200, 100, 1'b0, 5);
    for (int i = 0; i < 6; i++)
      do_op("rnd", $urandom_range(0, M - 1), $urandom_range(0, M - 1), 1'(i % 2), 0);

    // Reset in SUM: abandon the operation.
    x = 8'd200; y = 8'd100; mode = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst_sum.out_valid", out_valid, 0);
    check("rst_sum.s", s, 0);
    check("rst_sum.err", err, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("rst_sum.in_ready", in_ready, 1);
    seen = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("rst_sum.no_result", seen, 0);

    // Reset in DONE: held result clears asynchronously.
    out_ready = 1'b0;
    x = 8'd200; y = 8'd100; mode = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    check("rst_done.pre_s", s, 49);
    rst_n = 1'b0;
    #1;
    check("rst_done.s", s, 0);
    check("rst_done.out_valid", out_valid, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    do_op("after_rst", 250, 250, 1'b0, 0);

    check("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=0 expected=1");
    $fatal(1, "timeout");
  end
endmodule
